dmi_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one DMI request/response channel between `NumReq` debug transport requesters, for example the JTAG DTM and a second BSCAN/test-access DTM. It sits in the `tck` domain, between the requesters' DMI FSMs and the JTAG side of `dmi_cdc`. It allows one transaction outstanding at a time and routes each response only to the requester that issued it.

---
 rtl/dmi_req_arbiter_if.sv | 42 ++++
 rtl/dmi_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmi_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_req_arbiter_if.sv
// DMI payload types and the bus bundle between requesters, the arbiter and the CDC.
package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

// Requester-side channels are per-requester vectors; CDC-side channel is single.
// slave = the arbiter's view, master = the surrounding requesters and CDC.
interface dmi_req_arbiter_if #(
    parameter int unsigned NumReq = 2
);
    dm::dmi_req_t  [NumReq-1:0] req;
    logic          [NumReq-1:0] req_valid;
    logic          [NumReq-1:0] req_ready;
    dm::dmi_resp_t              resp;
    logic          [NumReq-1:0] resp_valid;
    logic          [NumReq-1:0] resp_ready;
    dm::dmi_req_t               dmi_req;
    logic                       dmi_req_valid;
    logic                       dmi_req_ready;
    dm::dmi_resp_t              dmi_resp;
    logic                       dmi_resp_valid;
    logic                       dmi_resp_ready;

    modport slave (
        input  req, req_valid, resp_ready, dmi_req_ready, dmi_resp, dmi_resp_valid,
        output req_ready, resp, resp_valid, dmi_req, dmi_req_valid, dmi_resp_ready
    );

    modport master (
        output req, req_valid, resp_ready, dmi_req_ready, dmi_resp, dmi_resp_valid,
        input  req_ready, resp, resp_valid, dmi_req, dmi_req_valid, dmi_resp_ready
    );
endinterface

// File: rtl/dmi_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one DMI channel among NumReq requesters,
// one transaction in flight, responses routed back to the issuing requester.

// Per-requester decode of the shared grant and response-owner indices.
module dmi_req_arbiter_lane #(
    parameter int unsigned IdxW = 1,
    parameter int unsigned Lane = 0
) (
    input  logic            grant_en,
    input  logic [IdxW-1:0] win_idx,
    input  logic            rsp_en,
    input  logic [IdxW-1:0] owner,
    input  logic            dmi_resp_valid,
    output logic            req_ready,
    output logic            resp_valid
);
    assign req_ready  = grant_en && (win_idx == IdxW'(Lane));
    assign resp_valid = rsp_en && (owner == IdxW'(Lane)) && dmi_resp_valid;
endmodule

module dmi_req_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             clear_i,
    dmi_req_arbiter_if.slave bus,
    output logic             busy_o,
    output logic [IdxW-1:0]  grant_idx_o
);
    typedef enum logic [1:0] {Idle, Req, Resp} state_e;

    localparam logic [IdxW-1:0] LastRst = IdxW'(NumReq - 1);

    state_e          state_q, state_d;
    dm::dmi_req_t    req_q, req_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;

    logic            win_vld;
    logic [IdxW-1:0] win_idx;
    logic            accept;
    logic            rsp_done;
    logic [NumReq-1:0] req_ready_v, resp_valid_v;

    // Round-robin search: first valid requester after the last completed owner.
    // Walking the offsets downward lets the nearest hit overwrite farther ones.
    always_comb begin
        int unsigned j;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int unsigned k = NumReq; k >= 1; k--) begin
            j = (32'(last_q) + k) % NumReq;
            if (bus.req_valid[j[IdxW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = j[IdxW-1:0];
            end
        end
    end

    // Grant is suppressed during reset and clear so nobody sees a false acceptance.
    assign accept   = trst_ni && !clear_i && (state_q == Idle) && win_vld;
    assign rsp_done = (state_q == Resp) && bus.dmi_resp_valid && bus.resp_ready[owner_q];

    // Next-state: Idle -> Req -> Resp -> Idle; clear overrides every transition.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            Idle: if (accept) begin
                state_d = Req;
                req_d   = bus.req[win_idx];
                owner_d = win_idx;
            end
            Req:  if (bus.dmi_req_ready) state_d = Resp;
            Resp: if (rsp_done) begin
                state_d = Idle;
                last_d  = owner_q;
            end
            default: state_d = Idle;
        endcase
        if (clear_i) begin
            state_d = Idle;
            req_d   = '0;
            owner_d = '0;
            last_d  = LastRst;
        end
    end

    // State and request registers; the pointer resets so requester 0 wins first.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= Idle;
            req_q   <= '0;
            owner_q <= '0;
            last_q  <= LastRst;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_lane
        dmi_req_arbiter_lane #(
            .IdxW (IdxW),
            .Lane (i)
        ) u_lane (
            .grant_en       (accept),
            .win_idx        (win_idx),
            .rsp_en         (state_q == Resp),
            .owner          (owner_q),
            .dmi_resp_valid (bus.dmi_resp_valid),
            .req_ready      (req_ready_v[i]),
            .resp_valid     (resp_valid_v[i])
        );
    end

    assign bus.req_ready  = req_ready_v;
    assign bus.resp_valid = resp_valid_v;
    assign bus.resp       = bus.dmi_resp;

    // Request side is register-driven; clear only masks valid so no handshake lands on it.
    assign bus.dmi_req       = req_q;
    assign bus.dmi_req_valid = (state_q == Req) && !clear_i;

    // Idle drains stray CDC responses; Resp follows the owner's backpressure.
    always_comb begin
        bus.dmi_resp_ready = 1'b0;
        unique case (state_q)
            Idle:    bus.dmi_resp_ready = 1'b1;
            Resp:    bus.dmi_resp_ready = bus.resp_ready[owner_q];
            default: bus.dmi_resp_ready = 1'b0;
        endcase
    end

    assign busy_o      = (state_q != Idle);
    assign grant_idx_o = owner_q;
endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Scoreboard bench for dmi_req_arbiter: random transactions plus directed corner cases.
module tb_dmi_req_arbiter;
    localparam int N  = 2;
    localparam int IW = $clog2(N);

    typedef struct { int idx; dm::dmi_req_t  rq; } acc_t;
    typedef struct { int idx; dm::dmi_resp_t rs; } rsp_t;

    logic          tck = 1'b0;
    logic          trst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          busy;
    logic [IW-1:0] grant_idx;

    dmi_req_arbiter_if #(.NumReq(N)) bus ();

    dmi_req_arbiter #(.NumReq(N)) dut (
        .tck_i       (tck),
        .trst_ni     (trst_ni),
        .clear_i     (clear_i),
        .bus         (bus),
        .busy_o      (busy),
        .grant_idx_o (grant_idx)
    );

    always #5 tck = ~tck;

    acc_t acc_q[$];
    acc_t dmi_q[$];
    rsp_t rsp_q[$];
    int   grants[$];
    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 1'b0;
    int   rr_last = N - 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration rule: first valid requester after the last completed owner.
    function automatic int pick(input logic [N-1:0] m);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (rr_last + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic int ohidx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic dm::dmi_req_t rnd_req();
        dm::dmi_req_t r;
        r.addr = 7'($urandom);
        r.op   = 2'($urandom);
        r.data = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // One full transaction; expectations are queued before any stimulus is applied.
    task automatic do_txn(input logic [N-1:0] mask, input int cdc_dly, input int rsp_dly,
                          input int own_dly, input logic [31:0] rdata, input bit early);
        int w;
        dm::dmi_resp_t rs;
        for (int i = 0; i < N; i++) bus.req[i] = rnd_req();
        w = pick(mask);
        acc_q.push_back(acc_t'{idx: w, rq: bus.req[w]});
        rs.data = rdata;
        rs.resp = 2'($urandom);
        rsp_q.push_back(rsp_t'{idx: w, rs: rs});
        bus.req_valid = mask;
        tick();
        for (int c = 0; c < cdc_dly; c++) begin
            bus.req_valid = N'($urandom);
            if (early) begin
                bus.dmi_resp       = dm::dmi_resp_t'{data: ~rdata, resp: 2'b00};
                bus.dmi_resp_valid = 1'b1;
            end
            @(negedge tck);
            if (early) begin
                chk("early_rsp_ready", 64'(bus.dmi_resp_ready), 64'd0);
                chk("early_rsp_fwd", 64'(bus.resp_valid), 64'd0);
            end
            tick();
        end
        bus.dmi_resp_valid = 1'b0;
        bus.dmi_req_ready  = 1'b1;
        tick();
        bus.dmi_req_ready  = 1'b0;
        bus.resp_ready     = N'($urandom);
        bus.resp_ready[w]  = 1'b0;
        repeat (rsp_dly) begin
            bus.req_valid = N'($urandom);
            tick();
        end
        bus.dmi_resp       = rs;
        bus.dmi_resp_valid = 1'b1;
        repeat (own_dly) tick();
        bus.resp_ready[w]  = 1'b1;
        tick();
        bus.dmi_resp_valid = 1'b0;
        bus.resp_ready     = '0;
        bus.req_valid      = '0;
        rr_last = w;
    endtask

    // Monitor: pops and compares whenever the DUT presents a grant, request or response.
    initial forever begin
        int g;
        acc_t e;
        @(negedge tck);
        if (sb_on && trst_ni) begin
            if (bus.dmi_req_valid) begin
                if (dmi_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dmi_req_spurious: got valid=1 expected none pending");
                end else begin
                    chk("dmi_req", 64'(bus.dmi_req), 64'(dmi_q[0].rq));
                    chk("grant_idx_o", 64'(grant_idx), 64'(dmi_q[0].idx));
                    chk("busy_req", 64'(busy), 64'd1);
                    if (bus.dmi_req_ready) void'(dmi_q.pop_front());
                end
            end
            if (|bus.req_ready) begin
                if (!$onehot(bus.req_ready) || acc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_spurious: got req_ready=%b expected pending=%0d", bus.req_ready, acc_q.size());
                end else begin
                    g = ohidx(bus.req_ready);
                    e = acc_q.pop_front();
                    chk("grant_winner", 64'(g), 64'(e.idx));
                    grants.push_back(g);
                    dmi_q.push_back(e);
                end
            end
            if (|bus.resp_valid) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_spurious: got resp_valid=%b expected none", bus.resp_valid);
                end else begin
                    chk("resp_owner", 64'(bus.resp_valid), 64'd1 << rsp_q[0].idx);
                    chk("resp_data", 64'(bus.resp), 64'(rsp_q[0].rs));
                    chk("resp_rdy_fwd", 64'(bus.dmi_resp_ready), 64'(bus.resp_ready[rsp_q[0].idx]));
                    if (bus.resp_ready[rsp_q[0].idx]) void'(rsp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int rr_exp[4];
        logic [N-1:0] m;
        int cd;
        rr_exp = '{0, 1, 0, 1};

        // Reset with random inputs
        repeat (3) begin
            bus.req_valid      = N'($urandom);
            for (int i = 0; i < N; i++) bus.req[i] = rnd_req();
            bus.resp_ready     = N'($urandom);
            bus.dmi_req_ready  = 1'($urandom);
            bus.dmi_resp       = dm::dmi_resp_t'({$urandom, 2'($urandom)});
            bus.dmi_resp_valid = 1'($urandom);
            clear_i            = 1'($urandom);
            @(negedge tck);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("rst_dmi_req_valid", 64'(bus.dmi_req_valid), 64'd0);
            chk("rst_dmi_resp_ready", 64'(bus.dmi_resp_ready), 64'd1);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_grant_idx", 64'(grant_idx), 64'd0);
            chk("rst_dmi_req", 64'(bus.dmi_req), 64'd0);
            tick();
        end
        bus.req_valid = '0; bus.resp_ready = '0; bus.dmi_req_ready = 1'b0;
        bus.dmi_resp_valid = 1'b0; clear_i = 1'b0;
        trst_ni = 1'b1;
        tick();

        // First request after reset from requester 1 only
        bus.req[0] = rnd_req();
        bus.req[1] = dm::dmi_req_t'{addr: 7'h11, op: 2'd2, data: 32'hDEADBEEF};
        bus.req_valid = 2'b10;
        @(negedge tck);
        chk("first_ready", 64'(bus.req_ready), 64'b10);
        tick();
        bus.req_valid = '0;
        @(negedge tck);
        chk("first_dmi_valid", 64'(bus.dmi_req_valid), 64'd1);
        chk("first_dmi_addr", 64'(bus.dmi_req.addr), 64'h11);
        chk("first_dmi_data", 64'(bus.dmi_req.data), 64'hDEADBEEF);
        chk("first_busy", 64'(busy), 64'd1);
        bus.dmi_req_ready = 1'b1;
        tick();
        bus.dmi_req_ready = 1'b0;
        bus.dmi_resp = dm::dmi_resp_t'{data: 32'h1234_5678, resp: 2'b00};
        bus.dmi_resp_valid = 1'b1;
        bus.resp_ready = 2'b10;
        @(negedge tck);
        chk("first_resp_owner", 64'(bus.resp_valid), 64'b10);
        chk("first_resp_data", 64'(bus.resp.data), 64'h1234_5678);
        tick();
        bus.dmi_resp_valid = 1'b0; bus.resp_ready = '0;
        rr_last = 1;
        @(negedge tck);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("grant_hold", 64'(grant_idx), 64'd1);
        tick();

        // Round robin with all requesters valid
        sb_on = 1'b1;
        grants.delete();
        for (int t = 0; t < 4; t++) do_txn(2'b11, 0, 0, 0, 32'(t + 1), 1'b0);
        chk("rr_count", 64'(grants.size()), 64'd4);
        for (int t = 0; t < 4 && t < grants.size(); t++)
            chk($sformatf("rr_order_%0d", t), 64'(grants[t]), 64'(rr_exp[t]));

        // Backpressure on both sides
        do_txn(2'b11, 5, 0, 3, $urandom, 1'b0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            do m = N'($urandom); while (m == '0);
            cd = $urandom_range(0, 3);
            do_txn(m, cd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   (cd > 0) && ($urandom_range(0, 2) == 0));
        end

        // Clear in Resp: make requester 0 the last owner, then abort requester 1
        do_txn(2'b01, 0, 0, 0, $urandom, 1'b0);
        sb_on = 1'b0;
        for (int i = 0; i < N; i++) bus.req[i] = rnd_req();
        bus.req_valid = 2'b10;
        @(negedge tck);
        chk("clr_grant", 64'(bus.req_ready), 64'b10);
        tick();
        bus.req_valid = '0;
        bus.dmi_req_ready = 1'b1;
        tick();
        bus.dmi_req_ready = 1'b0;
        clear_i = 1'b1;
        @(negedge tck);
        chk("clr_busy_before", 64'(busy), 64'd1);
        tick();
        clear_i = 1'b0;
        bus.dmi_resp = dm::dmi_resp_t'{data: $urandom, resp: 2'b00};
        bus.dmi_resp_valid = 1'b1;
        @(negedge tck);
        chk("clr_busy_after", 64'(busy), 64'd0);
        chk("clr_drain_ready", 64'(bus.dmi_resp_ready), 64'd1);
        chk("clr_drain_fwd", 64'(bus.resp_valid), 64'd0);
        tick();
        bus.dmi_resp_valid = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge tck);
        chk("clr_next_grant", 64'(bus.req_ready), 64'b01);
        tick();
        bus.req_valid = '0;
        bus.dmi_req_ready = 1'b1;
        tick();
        bus.dmi_req_ready = 1'b0;
        bus.dmi_resp_valid = 1'b1; bus.resp_ready = 2'b01;
        tick();
        bus.dmi_resp_valid = 1'b0; bus.resp_ready = '0;

        // Clear coinciding with an acceptance candidate
        bus.req_valid = 2'b01;
        clear_i = 1'b1;
        @(negedge tck);
        chk("sim_clr_ready", 64'(bus.req_ready), 64'd0);
        tick();
        clear_i = 1'b0;
        bus.req_valid = '0;
        @(negedge tck);
        chk("sim_clr_no_req", 64'(bus.dmi_req_valid), 64'd0);
        chk("sim_clr_busy", 64'(busy), 64'd0);
        rr_last = N - 1;
        tick();

        // Pointer restored by clear: requester 0 wins next
        sb_on = 1'b1;
        grants.delete();
        do_txn(2'b11, 1, 1, 1, $urandom, 1'b0);
        chk("post_clr_winner", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
        repeat (3) tick();
        sb_on = 1'b0;

        chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
        chk("dmi_q_empty", 64'(dmi_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
